sr_control_mc: RTL and testbench

SR_CONTROL_MC -- requirements
Module: sr_control_mc

---
 rtl/sr_cpu_pkg.sv | 52 +++++
 rtl/sr_control_decode.sv | 79 +++++++
 rtl/sr_control_mc.sv | 126 ++++++++++++
 tb/tb_sr_control_mc.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sr_cpu_pkg.sv
// rtl/sr_cpu_pkg.sv - shared encodings for the multi-cycle schoolRISCV control unit
package sr_cpu_pkg;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_IMM = 2'd1;
    localparam logic [1:0] WD_MUL = 2'd2;

    typedef enum logic [1:0] {
        MOP_MUL    = 2'd0,
        MOP_MULH   = 2'd1,
        MOP_MULHSU = 2'd2,
        MOP_MULHU  = 2'd3
    } mul_op_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SRL  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // The MUL family's F3 low bits already match the mulOp encoding.
    function automatic mul_op_e mul_op_from_f3(input logic [2:0] f3);
        return mul_op_e'(f3[1:0]);
    endfunction

endpackage

// File: rtl/sr_control_decode.sv
// rtl/sr_control_decode.sv - combinational instruction decode including the MUL family
module sr_control_decode
    import sr_cpu_pkg::*;
#(
    parameter bit EN_MULH = 1'b1
) (
    input  logic [6:0] cmd_op_i,
    input  logic [2:0] cmd_f3_i,
    input  logic [6:0] cmd_f7_i,
    output logic       branch_o,
    output logic       cond_zero_o,
    output logic       reg_write_o,
    output logic       alu_src_o,
    output logic [1:0] wd_src_o,
    output logic [2:0] alu_control_o,
    output logic       is_mul_o,
    output logic [1:0] mul_op_o,
    output logic       illegal_o
);

    logic mul_family;

    always_comb begin
        branch_o      = 1'b0;
        cond_zero_o   = 1'b0;
        reg_write_o   = 1'b0;
        alu_src_o     = 1'b0;
        wd_src_o      = WD_ALU;
        alu_control_o = ALU_ADD;
        illegal_o     = 1'b0;

        mul_family = (cmd_op_i == OP_OP) && (cmd_f7_i == F7_MUL) && !cmd_f3_i[2];
        is_mul_o   = mul_family && ((cmd_f3_i == F3_MUL) || EN_MULH);
        mul_op_o   = mul_op_from_f3(cmd_f3_i);

        casez ({cmd_f7_i, cmd_f3_i, cmd_op_i})
            {F7_BASE, F3_ADD, OP_OP}: begin
                reg_write_o   = 1'b1;
                alu_control_o = ALU_ADD;
            end
            {F7_BASE, F3_OR, OP_OP}: begin
                reg_write_o   = 1'b1;
                alu_control_o = ALU_OR;
            end
            {F7_BASE, F3_SRL, OP_OP}: begin
                reg_write_o   = 1'b1;
                alu_control_o = ALU_SRL;
            end
            {F7_BASE, F3_SLTU, OP_OP}: begin
                reg_write_o   = 1'b1;
                alu_control_o = ALU_SLTU;
            end
            {F7_ALT, F3_ADD, OP_OP}: begin
                reg_write_o   = 1'b1;
                alu_control_o = ALU_SUB;
            end
            {7'b???????, F3_ADD, OP_IMM}: begin
                reg_write_o   = 1'b1;
                alu_src_o     = 1'b1;
                alu_control_o = ALU_ADD;
            end
            {7'b???????, 3'b???, OP_LUI}: begin
                reg_write_o = 1'b1;
                wd_src_o    = WD_IMM;
            end
            {7'b???????, F3_BEQ, OP_BRANCH}: begin
                branch_o      = 1'b1;
                cond_zero_o   = 1'b1;
                alu_control_o = ALU_SUB;
            end
            {7'b???????, F3_BNE, OP_BRANCH}: begin
                branch_o      = 1'b1;
                alu_control_o = ALU_SUB;
            end
            default: illegal_o = !is_mul_o;
        endcase
    end

endmodule

// File: rtl/sr_control_mc.sv
// rtl/sr_control_mc.sv - multi-cycle control: single-cycle decode plus multiplier wait FSM
module sr_control_mc
    import sr_cpu_pkg::*;
#(
    parameter int MUL_TIMEOUT = 64,
    parameter bit EN_MULH     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] cmdOp,
    input  logic [2:0] cmdF3,
    input  logic [6:0] cmdF7,
    input  logic       aluZero,
    input  logic       mulDone,
    output logic       pcSrc,
    output logic       pcEnable,
    output logic       regWrite,
    output logic       aluSrc,
    output logic [1:0] wdSrc,
    output logic [2:0] aluControl,
    output logic       mulStart,
    output logic [1:0] mulOp,
    output logic       illegalInstr,
    output logic       mulError
);

    localparam int CW = $clog2(MUL_TIMEOUT + 1);

    logic          dec_branch, dec_cond_zero, dec_reg_write, dec_alu_src;
    logic [1:0]    dec_wd_src, dec_mul_op;
    logic [2:0]    dec_alu_control;
    logic          dec_is_mul, dec_illegal;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    sr_control_decode #(.EN_MULH(EN_MULH)) u_decode (
        .cmd_op_i      (cmdOp),
        .cmd_f3_i      (cmdF3),
        .cmd_f7_i      (cmdF7),
        .branch_o      (dec_branch),
        .cond_zero_o   (dec_cond_zero),
        .reg_write_o   (dec_reg_write),
        .alu_src_o     (dec_alu_src),
        .wd_src_o      (dec_wd_src),
        .alu_control_o (dec_alu_control),
        .is_mul_o      (dec_is_mul),
        .mul_op_o      (dec_mul_op),
        .illegal_o     (dec_illegal)
    );

    always_comb begin
        pcSrc        = 1'b0;
        pcEnable     = 1'b0;
        regWrite     = 1'b0;
        aluSrc       = 1'b0;
        wdSrc        = WD_ALU;
        aluControl   = ALU_ADD;
        mulStart     = 1'b0;
        mulOp        = MOP_MUL;
        illegalInstr = 1'b0;
        mulError     = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (dec_is_mul) begin
                    mulStart = 1'b1;
                    mulOp    = dec_mul_op;
                    state_d  = ST_MUL_WAIT;
                    cnt_d    = '0;
                end else begin
                    pcEnable     = 1'b1;
                    regWrite     = dec_reg_write;
                    aluSrc       = dec_alu_src;
                    wdSrc        = dec_wd_src;
                    aluControl   = dec_alu_control;
                    pcSrc        = dec_branch & (aluZero == dec_cond_zero);
                    illegalInstr = dec_illegal;
                end
            end
            ST_MUL_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (mulDone) begin
                    regWrite = 1'b1;
                    wdSrc    = WD_MUL;
                    pcEnable = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CW'(MUL_TIMEOUT - 1)) begin
                    mulError = 1'b1;
                    pcEnable = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are held quiet for the whole time reset is asserted.
        if (!rst_n) begin
            pcSrc        = 1'b0;
            pcEnable     = 1'b0;
            regWrite     = 1'b0;
            aluSrc       = 1'b0;
            wdSrc        = WD_ALU;
            aluControl   = ALU_ADD;
            mulStart     = 1'b0;
            mulOp        = MOP_MUL;
            illegalInstr = 1'b0;
            mulError     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sr_control_mc.sv
// tb/tb_sr_control_mc.sv - scoreboard bench for sr_control_mc
module tb_sr_control_mc;

    localparam logic [2:0] A_ADD = 3'd0, A_OR = 3'd1, A_SRL = 3'd2, A_SLTU = 3'd3, A_SUB = 3'd4;

    localparam logic [31:0] I_ADD   = 32'h00208133;
    localparam logic [31:0] I_SUB   = 32'h40208133;
    localparam logic [31:0] I_OR    = 32'h0020e133;
    localparam logic [31:0] I_SRL   = 32'h0020d133;
    localparam logic [31:0] I_SLTU  = 32'h0020b133;
    localparam logic [31:0] I_AND   = 32'h0020f133;
    localparam logic [31:0] I_ADDI  = 32'h00508113;
    localparam logic [31:0] I_LUI   = 32'h12345137;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_MUL   = 32'h02208133;
    localparam logic [31:0] I_MULH  = 32'h02209133;
    localparam logic [31:0] I_MULHU = 32'h0220b133;
    localparam logic [31:0] I_DIV   = 32'h0220c133;
    localparam logic [31:0] I_ZERO  = 32'h00000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] cmdOp = '0;
    logic [2:0] cmdF3 = '0;
    logic [6:0] cmdF7 = '0;
    logic       aluZero = 1'b0;
    logic       mulDone = 1'b0;

    logic       m_pcSrc, m_pcEnable, m_regWrite, m_aluSrc, m_mulStart, m_illegal, m_mulError;
    logic [1:0] m_wdSrc, m_mulOp;
    logic [2:0] m_aluControl;
    logic       n_pcSrc, n_pcEnable, n_regWrite, n_aluSrc, n_mulStart, n_illegal, n_mulError;
    logic [1:0] n_wdSrc, n_mulOp;
    logic [2:0] n_aluControl;

    int n_cmp = 0;
    int n_err = 0;

    string      q_tag[$];
    bit         q_sel[$];
    logic [13:0] q_exp[$];

    always #5 clk = ~clk;

    sr_control_mc #(.MUL_TIMEOUT(8), .EN_MULH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .mulDone(mulDone),
        .pcSrc(m_pcSrc), .pcEnable(m_pcEnable), .regWrite(m_regWrite), .aluSrc(m_aluSrc),
        .wdSrc(m_wdSrc), .aluControl(m_aluControl), .mulStart(m_mulStart), .mulOp(m_mulOp),
        .illegalInstr(m_illegal), .mulError(m_mulError)
    );

    sr_control_mc #(.EN_MULH(1'b0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .mulDone(mulDone),
        .pcSrc(n_pcSrc), .pcEnable(n_pcEnable), .regWrite(n_regWrite), .aluSrc(n_aluSrc),
        .wdSrc(n_wdSrc), .aluControl(n_aluControl), .mulStart(n_mulStart), .mulOp(n_mulOp),
        .illegalInstr(n_illegal), .mulError(n_mulError)
    );

    wire [13:0] obs_m = {m_pcSrc, m_pcEnable, m_regWrite, m_aluSrc, m_wdSrc, m_aluControl,
                         m_mulStart, m_mulOp, m_illegal, m_mulError};
    wire [13:0] obs_n = {n_pcSrc, n_pcEnable, n_regWrite, n_aluSrc, n_wdSrc, n_aluControl,
                         n_mulStart, n_mulOp, n_illegal, n_mulError};

    function automatic logic [13:0] E(input logic ps, input logic pe, input logic rw,
                                      input logic as, input logic [1:0] wd, input logic [2:0] alu,
                                      input logic ms, input logic [1:0] mo, input logic il,
                                      input logic er);
        return {ps, pe, rw, as, wd, alu, ms, mo, il, er};
    endfunction

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (ps pe rw as wd alu ms mo il er)", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic z, input logic d,
                        input logic r, input logic [13:0] em, input bit cn,
                        input logic [13:0] en);
        cmdOp   = ins[6:0];
        cmdF3   = ins[14:12];
        cmdF7   = ins[31:25];
        aluZero = z;
        mulDone = d;
        rst_n   = r;
        q_tag.push_back(tag); q_sel.push_back(1'b0); q_exp.push_back(em);
        if (cn) begin
            q_tag.push_back({tag, "_nh"}); q_sel.push_back(1'b1); q_exp.push_back(en);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            string       t;
            bit          s;
            logic [13:0] e;
            t = q_tag.pop_front();
            s = q_sel.pop_front();
            e = q_exp.pop_front();
            check_eq(t, s ? obs_n : obs_m, e);
        end
    end

    logic [13:0] Z, W_ADD, W_MUL, ILL, MERR;

    initial begin
        Z     = '0;
        W_ADD = E(0, 1, 1, 0, 2'd0, A_ADD, 0, 2'd0, 0, 0);
        W_MUL = E(0, 1, 1, 0, 2'd2, A_ADD, 0, 2'd0, 0, 0);
        ILL   = E(0, 1, 0, 0, 2'd0, A_ADD, 0, 2'd0, 1, 0);
        MERR  = E(0, 1, 0, 0, 2'd0, A_ADD, 0, 2'd0, 0, 1);

        @(posedge clk);
        #1;
        step("reset_out", I_ADD, 0, 0, 0, Z, 1, Z);
        step("add", I_ADD, 0, 0, 1, W_ADD, 1, W_ADD);

        step("mulh_start", I_MULH, 0, 0, 1, E(0, 0, 0, 0, 2'd0, A_ADD, 1, 2'd1, 0, 0), 1, ILL);
        step("mulh_done", I_MULH, 0, 1, 1, W_MUL, 1, ILL);

        step("sub", I_SUB, 0, 0, 1, E(0, 1, 1, 0, 2'd0, A_SUB, 0, 2'd0, 0, 0), 0, Z);
        step("or", I_OR, 0, 0, 1, E(0, 1, 1, 0, 2'd0, A_OR, 0, 2'd0, 0, 0), 0, Z);
        step("srl", I_SRL, 0, 0, 1, E(0, 1, 1, 0, 2'd0, A_SRL, 0, 2'd0, 0, 0), 0, Z);
        step("sltu", I_SLTU, 0, 0, 1, E(0, 1, 1, 0, 2'd0, A_SLTU, 0, 2'd0, 0, 0), 0, Z);
        step("addi", I_ADDI, 0, 0, 1, E(0, 1, 1, 1, 2'd0, A_ADD, 0, 2'd0, 0, 0), 0, Z);
        step("lui", I_LUI, 0, 0, 1, E(0, 1, 1, 0, 2'd1, A_ADD, 0, 2'd0, 0, 0), 0, Z);
        step("beq_z1", I_BEQ, 1, 0, 1, E(1, 1, 0, 0, 2'd0, A_SUB, 0, 2'd0, 0, 0), 0, Z);
        step("beq_z0", I_BEQ, 0, 0, 1, E(0, 1, 0, 0, 2'd0, A_SUB, 0, 2'd0, 0, 0), 0, Z);
        step("bne_z1", I_BNE, 1, 0, 1, E(0, 1, 0, 0, 2'd0, A_SUB, 0, 2'd0, 0, 0), 0, Z);
        step("bne_z0", I_BNE, 0, 0, 1, E(1, 1, 0, 0, 2'd0, A_SUB, 0, 2'd0, 0, 0), 0, Z);
        step("idle_done", I_BEQ, 0, 1, 1, E(0, 1, 0, 0, 2'd0, A_SUB, 0, 2'd0, 0, 0), 0, Z);
        step("after_idle_done", I_ADD, 0, 0, 1, W_ADD, 0, Z);
        step("ill_zero", I_ZERO, 0, 0, 1, ILL, 0, Z);
        step("ill_and", I_AND, 1, 0, 1, ILL, 0, Z);
        step("ill_div", I_DIV, 0, 0, 1, ILL, 0, Z);

        step("mul_start", I_MUL, 0, 0, 1, E(0, 0, 0, 0, 2'd0, A_ADD, 1, 2'd0, 0, 0), 0, Z);
        step("mul_wait1", I_MUL, 0, 0, 1, Z, 0, Z);
        step("mul_wait2", I_MUL, 0, 0, 1, Z, 0, Z);
        step("mul_done", I_MUL, 0, 1, 1, W_MUL, 0, Z);

        step("b2b_start1", I_MULHU, 0, 0, 1, E(0, 0, 0, 0, 2'd0, A_ADD, 1, 2'd3, 0, 0), 0, Z);
        step("b2b_done1", I_MULHU, 0, 1, 1, W_MUL, 0, Z);
        step("b2b_start2", I_MUL, 0, 0, 1, E(0, 0, 0, 0, 2'd0, A_ADD, 1, 2'd0, 0, 0), 0, Z);
        step("b2b_done2", I_MUL, 0, 1, 1, W_MUL, 0, Z);

        step("to_start", I_MUL, 0, 0, 1, E(0, 0, 0, 0, 2'd0, A_ADD, 1, 2'd0, 0, 0), 0, Z);
        for (int i = 0; i < 7; i++) step("to_wait", I_MUL, 0, 0, 1, Z, 0, Z);
        step("to_error", I_MUL, 0, 0, 1, MERR, 0, Z);
        step("after_to", I_ADD, 0, 0, 1, W_ADD, 0, Z);

        step("co_start", I_MUL, 0, 0, 1, E(0, 0, 0, 0, 2'd0, A_ADD, 1, 2'd0, 0, 0), 0, Z);
        for (int i = 0; i < 7; i++) step("co_wait", I_MUL, 0, 0, 1, Z, 0, Z);
        step("co_done_wins", I_MUL, 0, 1, 1, W_MUL, 0, Z);

        step("rst_start", I_MUL, 0, 0, 1, E(0, 0, 0, 0, 2'd0, A_ADD, 1, 2'd0, 0, 0), 0, Z);
        step("rst_wait1", I_MUL, 0, 0, 1, Z, 0, Z);
        step("rst_wait2", I_MUL, 0, 0, 1, Z, 0, Z);
        step("rst_low", I_MUL, 0, 0, 0, Z, 1, Z);
        step("rst_done_ign", I_BEQ, 0, 1, 1, E(0, 1, 0, 0, 2'd0, A_SUB, 0, 2'd0, 0, 0), 0, Z);
        step("rst_after", I_ADD, 0, 0, 1, W_ADD, 1, W_ADD);

        @(negedge clk);
        #1;
        check_eq("sb_drain", 14'(q_exp.size()), 14'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
